thread_sched: RTL

THREAD_SCHED -- requirements
Module: thread_sched

---
 rtl/thread_pkg.sv | 16 +
 rtl/thread_sched_rr_arb4.sv | 35 +++
 rtl/thread_sched.sv | 95 +++++++++
 3 files changed

// File: rtl/thread_pkg.sv
// Shared types and constants for the 4-thread barrel scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package thread_pkg;

  localparam int NUM_THREADS = 4;
  localparam int NUM_STAGES  = 5;

  // One-hot thread owner; all-zero means no thread owns the slot.
  typedef logic [NUM_THREADS-1:0] thread_t;

  localparam thread_t BUBBLE         = '0;
  // Last-grant value after reset, chosen so the rotation starts at thread 0.
  localparam thread_t LAST_GRANT_RST = 4'b1000;

endpackage

// File: rtl/thread_sched_rr_arb4.sv
// Rotating-priority arbiter: first requester strictly after 'last', wrapping 3->0.
// Latency: combinational.
// Backpressure: none; gnt is all-zero when no request is present.
module rr_arb4
  import thread_pkg::*;
(
  input  logic [3:0] req,
  input  logic [3:0] last,
  output logic [3:0] gnt
);

  logic [1:0] last_idx;
  logic [1:0] idx;
  logic       found;

  // Locate the previous winner, then scan the four positions after it.
  always_comb begin
    gnt      = BUBBLE;
    last_idx = 2'd3;
    idx      = 2'd0;
    found    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (last[i]) last_idx = 2'(i);
    end
    // Offsets 1..4; offset 4 wraps back to the previous winner itself.
    for (int k = 1; k <= 4; k++) begin
      idx = last_idx + 2'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_sched.sv
// Barrel-thread scheduler: rotating issue into IF, per-stage ownership tracking, block/unblock.
// Latency: grant to thread_sel_IF 1 cycle; block_req to blocked/redirect/squash 1 cycle.
// Backpressure: stall freezes all stage registers and last_grant; squash still applies.
module thread_sched
  import thread_pkg::*;
#(
  parameter int NUM_THREADS = thread_pkg::NUM_THREADS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_THREADS-1:0] thread_en,
  input  logic                   stall,
  input  logic                   block_req,
  input  logic [NUM_THREADS-1:0] block_done,
  output logic [NUM_THREADS-1:0] thread_sel_IF,
  output logic [NUM_THREADS-1:0] thread_sel_ID,
  output logic [NUM_THREADS-1:0] thread_sel_EX,
  output logic [NUM_THREADS-1:0] thread_sel_MEM,
  output logic [NUM_THREADS-1:0] thread_sel_WB,
  output logic                   issue_valid,
  output logic [NUM_THREADS-1:0] redirect,
  output logic [NUM_THREADS-1:0] blocked
);

  thread_t last_grant;
  thread_t block_set;
  thread_t eligible;
  thread_t gnt;

  thread_t if_nxt, id_nxt, ex_nxt, mem_nxt, wb_nxt;
  thread_t last_nxt, blocked_nxt;
  logic    squash_if, squash_id;

  // Thread being blocked this cycle (only when EX actually holds a thread).
  always_comb begin
    block_set = BUBBLE;
    if (block_req && (thread_sel_EX != BUBBLE)) block_set = thread_sel_EX;
    eligible  = thread_en & ~blocked & ~block_set;
  end

  rr_arb4 u_arb (
    .req  (eligible),
    .last (last_grant),
    .gnt  (gnt)
  );

  // Next-state for the stage pipeline, rotation pointer and blocked mask.
  always_comb begin
    squash_if   = (block_set != BUBBLE) && (thread_sel_IF == block_set);
    squash_id   = (block_set != BUBBLE) && (thread_sel_ID == block_set);
    blocked_nxt = (blocked & ~block_done) | block_set;
    if (stall) begin
      if_nxt   = squash_if ? BUBBLE : thread_sel_IF;
      id_nxt   = squash_id ? BUBBLE : thread_sel_ID;
      ex_nxt   = thread_sel_EX;
      mem_nxt  = thread_sel_MEM;
      wb_nxt   = thread_sel_WB;
      last_nxt = last_grant;
    end else begin
      // A squashed instruction becomes a bubble as it moves down.
      if_nxt   = gnt;
      id_nxt   = squash_if ? BUBBLE : thread_sel_IF;
      ex_nxt   = squash_id ? BUBBLE : thread_sel_ID;
      mem_nxt  = thread_sel_EX;
      wb_nxt   = thread_sel_MEM;
      last_nxt = (gnt != BUBBLE) ? gnt : last_grant;
    end
  end

  // State registers; reset dominates stall and block traffic.
  always_ff @(posedge clk) begin
    if (reset) begin
      thread_sel_IF  <= BUBBLE;
      thread_sel_ID  <= BUBBLE;
      thread_sel_EX  <= BUBBLE;
      thread_sel_MEM <= BUBBLE;
      thread_sel_WB  <= BUBBLE;
      blocked        <= BUBBLE;
      redirect       <= BUBBLE;
      last_grant     <= LAST_GRANT_RST;
    end else begin
      thread_sel_IF  <= if_nxt;
      thread_sel_ID  <= id_nxt;
      thread_sel_EX  <= ex_nxt;
      thread_sel_MEM <= mem_nxt;
      thread_sel_WB  <= wb_nxt;
      blocked        <= blocked_nxt;
      redirect       <= block_set;
      last_grant     <= last_nxt;
    end
  end

  assign issue_valid = (thread_sel_IF != BUBBLE);

endmodule
